// File: rtl/axis_bram_line_packer_pkg.sv
// Shared definitions for the AXIS-to-BRAM adapter: FSM encoding and default geometry
// common to the write-side packer and the read-side controller.
package axis_bram_line_packer_pkg;

  localparam int DEF_WORD_WIDTH         = 32;
  localparam int DEF_BRAM_WIDTH_IN_WORD = 36;
  localparam int DEF_BRAM_ADDR_LENGTH   = 9;
  localparam int DEF_LINE_WIDTH         = DEF_WORD_WIDTH * DEF_BRAM_WIDTH_IN_WORD;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/axis_bram_line_packer_line_buffer_slots.sv
// Slot-indexed line register: one word written per strobe, synchronous clear.
// The line output already reflects this cycle's write/clear so a completed line can be captured in one edge.
module line_buffer_slots #(
  parameter int WORD_WIDTH = 32,
  parameter int SLOTS      = 36,
  parameter int CNT_BITS   = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        wr,
  input  logic [CNT_BITS-1:0]         slot,
  input  logic [WORD_WIDTH-1:0]       word,
  output logic [WORD_WIDTH*SLOTS-1:0] line
);

  logic [WORD_WIDTH*SLOTS-1:0] slots_q;

  always_comb begin
    line = slots_q;
    if (clr) begin
      line = '0;
    end else if (wr) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (int'(slot) == k) line[k*WORD_WIDTH +: WORD_WIDTH] = word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) slots_q <= '0;
    else     slots_q <= line;
  end

endmodule

// File: rtl/axis_bram_line_packer.sv
// Write-side packer: gathers BRAM_WIDTH_IN_WORD stream words into one wide line and
// writes each line to consecutive BRAM indices, flagging tlast framing errors.
module axis_bram_line_packer
  import axis_bram_line_packer_pkg::*;
#(
  parameter int WORD_WIDTH         = DEF_WORD_WIDTH,
  parameter int BRAM_WIDTH_IN_WORD = DEF_BRAM_WIDTH_IN_WORD,
  parameter int BRAM_ADDR_LENGTH   = DEF_BRAM_ADDR_LENGTH,
  parameter int CNT_BITS           = 6
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [BRAM_ADDR_LENGTH-1:0]              index_cntl,
  input  logic [BRAM_ADDR_LENGTH:0]                line_count,
  input  logic [WORD_WIDTH-1:0]                    s_axis_tdata,
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  input  logic                                     s_axis_tlast,
  output logic                                     bram_en,
  output logic                                     bram_wen,
  output logic [BRAM_ADDR_LENGTH-1:0]              bram_index,
  output logic [WORD_WIDTH*BRAM_WIDTH_IN_WORD-1:0] bram_din,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err_early_tlast,
  output logic                                     err_missing_tlast,
  output logic [CNT_BITS-1:0]                      cnt
);

  localparam int LINE_W = WORD_WIDTH * BRAM_WIDTH_IN_WORD;
  localparam logic [BRAM_ADDR_LENGTH:0] ONE_LINE  = 1;
  localparam logic [CNT_BITS-1:0]       LAST_SLOT = CNT_BITS'(BRAM_WIDTH_IN_WORD - 1);

  state_t                  state, state_nxt;
  logic [BRAM_ADDR_LENGTH:0] lines_left;
  logic                    ending;
  logic                    accept, last_slot, final_word, line_closes;
  logic                    buf_clr;
  logic [LINE_W-1:0]       line;

  assign accept      = (state == S_FILL) && s_axis_tvalid;
  assign last_slot   = (cnt == LAST_SLOT);
  assign final_word  = last_slot && (lines_left == ONE_LINE);
  assign line_closes = accept && (last_slot || s_axis_tlast);
  assign buf_clr     = ((state == S_IDLE) && start) || (state == S_WRITE);

  line_buffer_slots #(
    .WORD_WIDTH (WORD_WIDTH),
    .SLOTS      (BRAM_WIDTH_IN_WORD),
    .CNT_BITS   (CNT_BITS)
  ) u_slots (
    .clk  (clk),
    .rst  (rst),
    .clr  (buf_clr),
    .wr   (accept),
    .slot (cnt),
    .word (s_axis_tdata),
    .line (line)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    bram_en       = 1'b0;
    bram_wen      = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (line_count == '0) ? S_DONE : S_FILL;
      end
      S_FILL: begin
        s_axis_tready = 1'b1;
        busy          = 1'b1;
        if (line_closes) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        bram_en   = 1'b1;
        bram_wen  = 1'b1;
        busy      = 1'b1;
        state_nxt = ((lines_left == ONE_LINE) || ending) ? S_DONE : S_FILL;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bram_index        <= '0;
      bram_din          <= '0;
      lines_left        <= '0;
      ending            <= 1'b0;
      err_early_tlast   <= 1'b0;
      err_missing_tlast <= 1'b0;
      cnt               <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bram_index        <= index_cntl;
            lines_left        <= line_count;
            ending            <= 1'b0;
            err_early_tlast   <= 1'b0;
            err_missing_tlast <= 1'b0;
            cnt               <= '0;
          end
        end
        S_FILL: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            // Any tlast short of the final word closes the line and ends the transfer.
            if (s_axis_tlast && !final_word) begin
              err_early_tlast <= 1'b1;
              ending          <= 1'b1;
            end
            if (final_word && !s_axis_tlast) err_missing_tlast <= 1'b1;
          end
          if (line_closes) bram_din <= line;
        end
        S_WRITE: begin
          bram_index <= bram_index + 1'b1;
          lines_left <= lines_left - 1'b1;
          cnt        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_bram_line_packer.sv
// Randomized bench for axis_bram_line_packer with a line-level reference model.
`timescale 1ns/1ps
module tb_axis_bram_line_packer;
  import axis_bram_line_packer_pkg::*;

  localparam int WW = 32;
  localparam int NW = 36;
  localparam int AW = 9;
  localparam int CB = 6;
  localparam int LW = DEF_LINE_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] index_cntl = '0;
  logic [AW:0]   line_count = '0;
  logic [WW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          bram_en, bram_wen;
  logic [AW-1:0] bram_index;
  logic [LW-1:0] bram_din;
  logic          busy, done, err_early_tlast, err_missing_tlast;
  logic [CB-1:0] cnt;

  always #5 clk = ~clk;

  axis_bram_line_packer dut (
    .clk(clk), .rst(rst), .start(start), .index_cntl(index_cntl), .line_count(line_count),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .bram_en(bram_en), .bram_wen(bram_wen), .bram_index(bram_index),
    .bram_din(bram_din), .busy(busy), .done(done), .err_early_tlast(err_early_tlast),
    .err_missing_tlast(err_missing_tlast), .cnt(cnt)
  );

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int wr_tready = 0;
  int obs_idx[$];
  int obs_cyc[$];
  logic [LW-1:0] obs_line[$];

  int exp_idx[$];
  logic [LW-1:0] exp_line[$];
  bit exp_early, exp_miss;
  int exp_end;
  logic [WW-1:0] wdata[$];
  bit wlast[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_en && bram_wen) begin
      obs_idx.push_back(int'(bram_index));
      obs_line.push_back(bram_din);
      obs_cyc.push_back(cyc);
      if (s_axis_tready) wr_tready++;
    end
    if (done) done_cnt++;
  end

  function automatic int first_diff(input logic [LW-1:0] a, input logic [LW-1:0] b);
    for (int j = 0; j < NW; j++) if (a[j*WW +: WW] !== b[j*WW +: WW]) return j;
    return 0;
  endfunction

  task automatic mk_words(input int n, input int tl, input bit seq);
    wdata.delete(); wlast.delete();
    for (int i = 0; i < n; i++) begin
      wdata.push_back(seq ? WW'(i) : WW'($urandom));
      wlast.push_back(i == tl);
    end
  endtask

  // Reference: walk the word list line by line; trims wdata to the words the transfer consumes.
  task automatic model(input int idx, input int lc);
    logic [LW-1:0] b;
    int ln, sl, used;
    bit fin;
    exp_idx.delete(); exp_line.delete();
    exp_early = 0; exp_miss = 0;
    b = '0; ln = 0; sl = 0; used = 0;
    for (int i = 0; i < wdata.size(); i++) begin
      fin = (ln == lc - 1) && (sl == NW - 1);
      b[sl*WW +: WW] = wdata[i];
      used = i + 1;
      if (wlast[i] && !fin) exp_early = 1;
      if (fin && !wlast[i]) exp_miss = 1;
      if (sl == NW - 1 || wlast[i]) begin
        exp_idx.push_back((idx + ln) % (1 << AW));
        exp_line.push_back(b);
        b = '0; sl = 0; ln++;
        if (ln == lc || wlast[i]) break;
      end else begin
        sl++;
      end
    end
    exp_end = (idx + ln) % (1 << AW);
    while (wdata.size() > used) begin
      void'(wdata.pop_back());
      void'(wlast.pop_back());
    end
  endtask

  task automatic send_start(input int idx, input int lc);
    start = 1'b1; index_cntl = AW'(idx); line_count = (AW+1)'(lc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_words(input int from, input int to, input int vmode);
    int i, t;
    bit hs;
    i = from; t = 0;
    while (i < to && t < (to - from) * 20 + 50) begin
      s_axis_tdata  = wdata[i];
      s_axis_tlast  = wlast[i];
      s_axis_tvalid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk); hs = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (hs) i++;
      t++;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    nvec++;
    if (i != to) begin nfail++; $display("FAIL drive_words: accepted %0d words, required %0d", i - from, to - from); end
  endtask

  task automatic wait_done(input int d0);
    for (int t = 0; t < 300 && done_cnt == d0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if ({s_axis_tready, bram_en, bram_wen, busy, done, err_early_tlast, err_missing_tlast} !== 7'd0) begin
      nfail++; $display("FAIL reset_ctrl: got %b required 0000000", {s_axis_tready, bram_en, bram_wen, busy, done, err_early_tlast, err_missing_tlast}); end
    nvec++; if (bram_index !== '0) begin nfail++; $display("FAIL reset_index: got %0d required 0", bram_index); end
    nvec++; if (cnt !== '0) begin nfail++; $display("FAIL reset_cnt: got %0d required 0", cnt); end
    nvec++; if (bram_din !== '0) begin nfail++; $display("FAIL reset_din: got nonzero required 0"); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal(input int vmode, input string tn);
    int w0, d0;
    w0 = obs_idx.size(); d0 = done_cnt;
    mk_words(2*NW, 2*NW - 1, 1);
    model(5, 2);
    send_start(5, 2);
    nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL %s busy: got %b required 1", tn, busy); end
    drive_words(0, wdata.size(), vmode);
    wait_done(d0);
    nvec++; if (obs_idx.size() - w0 != exp_idx.size()) begin nfail++; $display("FAIL %s nwrites: got %0d required %0d", tn, obs_idx.size() - w0, exp_idx.size()); end
    for (int k = 0; k < exp_idx.size() && w0 + k < obs_idx.size(); k++) begin
      nvec++; if (obs_idx[w0+k] != exp_idx[k]) begin nfail++; $display("FAIL %s index%0d: got %0d required %0d", tn, k, obs_idx[w0+k], exp_idx[k]); end
      nvec++; if (obs_line[w0+k] !== exp_line[k]) begin nfail++;
        $display("FAIL %s line%0d slot %0d: got %h required %h", tn, k, first_diff(obs_line[w0+k], exp_line[k]),
                 obs_line[w0+k][first_diff(obs_line[w0+k], exp_line[k])*WW +: WW], exp_line[k][first_diff(obs_line[w0+k], exp_line[k])*WW +: WW]); end
    end
    if (vmode == 0 && obs_idx.size() - w0 == 2) begin
      nvec++; if (obs_cyc[w0+1] - obs_cyc[w0] != NW + 1) begin nfail++; $display("FAIL %s write_gap: got %0d required %0d", tn, obs_cyc[w0+1] - obs_cyc[w0], NW + 1); end
    end
    nvec++; if ({err_early_tlast, err_missing_tlast} !== {exp_early, exp_miss}) begin nfail++; $display("FAIL %s errs: got %b%b required %b%b", tn, err_early_tlast, err_missing_tlast, exp_early, exp_miss); end
    nvec++; if (int'(bram_index) != exp_end) begin nfail++; $display("FAIL %s final_index: got %0d required %0d", tn, bram_index, exp_end); end
    nvec++; if (done_cnt - d0 != 1) begin nfail++; $display("FAIL %s done_pulses: got %0d required 1", tn, done_cnt - d0); end
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL %s busy_after: got %b required 0", tn, busy); end
    nvec++; if (wr_tready != 0) begin nfail++; $display("FAIL %s tready_in_write: got %0d cycles required 0", tn, wr_tready); end
  endtask

  task automatic test_framing(input int idx, input int lc, input int n, input int tl, input int vmode, input string tn);
    int w0, d0;
    w0 = obs_idx.size(); d0 = done_cnt;
    mk_words(n, tl, 0);
    model(idx, lc);
    send_start(idx, lc);
    drive_words(0, wdata.size(), vmode);
    wait_done(d0);
    nvec++; if (obs_idx.size() - w0 != exp_idx.size()) begin nfail++; $display("FAIL %s nwrites: got %0d required %0d", tn, obs_idx.size() - w0, exp_idx.size()); end
    for (int k = 0; k < exp_idx.size() && w0 + k < obs_idx.size(); k++) begin
      nvec++; if (obs_idx[w0+k] != exp_idx[k]) begin nfail++; $display("FAIL %s index%0d: got %0d required %0d", tn, k, obs_idx[w0+k], exp_idx[k]); end
      nvec++; if (obs_line[w0+k] !== exp_line[k]) begin nfail++;
        $display("FAIL %s line%0d: first bad slot %0d", tn, k, first_diff(obs_line[w0+k], exp_line[k])); end
    end
    nvec++; if ({err_early_tlast, err_missing_tlast} !== {exp_early, exp_miss}) begin nfail++; $display("FAIL %s errs: got %b%b required %b%b", tn, err_early_tlast, err_missing_tlast, exp_early, exp_miss); end
    nvec++; if (int'(bram_index) != exp_end) begin nfail++; $display("FAIL %s final_index: got %0d required %0d", tn, bram_index, exp_end); end
    nvec++; if (done_cnt - d0 != 1) begin nfail++; $display("FAIL %s done_pulses: got %0d required 1", tn, done_cnt - d0); end
  endtask

  task automatic test_reset_mid_line;
    int w0;
    w0 = obs_idx.size();
    mk_words(20, -1, 0);
    send_start(20, 1);
    drive_words(0, 20, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    nvec++; if ({s_axis_tready, bram_en, bram_wen, busy, done, err_early_tlast, err_missing_tlast} !== 7'd0) begin
      nfail++; $display("FAIL midrst_ctrl: got %b required 0000000", {s_axis_tready, bram_en, bram_wen, busy, done, err_early_tlast, err_missing_tlast}); end
    nvec++; if (bram_index !== '0 || cnt !== '0 || bram_din !== '0) begin nfail++; $display("FAIL midrst_regs: index %0d cnt %0d, required 0 0 and zero line", bram_index, cnt); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (obs_idx.size() != w0) begin nfail++; $display("FAIL midrst_nowrite: got %0d writes required 0", obs_idx.size() - w0); end
    test_framing(100, 1, NW, NW - 1, 0, "after_reset");
  endtask

  task automatic test_line_count_zero;
    int w0, d0;
    w0 = obs_idx.size(); d0 = done_cnt;
    send_start(3, 0);
    nvec++; if ({done, s_axis_tready, busy} !== 3'b100) begin nfail++; $display("FAIL lc0_done: got done/tready/busy %b required 100", {done, s_axis_tready, busy}); end
    @(posedge clk); #1;
    nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL lc0_done_width: got %b required 0", done); end
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (obs_idx.size() != w0 || done_cnt - d0 != 1) begin nfail++; $display("FAIL lc0_quiet: got %0d writes %0d dones required 0 1", obs_idx.size() - w0, done_cnt - d0); end
  endtask

  task automatic test_start_during_busy;
    int w0, d0;
    w0 = obs_idx.size(); d0 = done_cnt;
    mk_words(NW, NW - 1, 0);
    model(40, 1);
    send_start(40, 1);
    drive_words(0, 10, 0);
    send_start(200, 0);
    drive_words(10, NW, 0);
    wait_done(d0);
    nvec++; if (obs_idx.size() - w0 != 1) begin nfail++; $display("FAIL busy_start nwrites: got %0d required 1", obs_idx.size() - w0); end
    if (obs_idx.size() - w0 == 1) begin
      nvec++; if (obs_idx[w0] != 40 || obs_line[w0] !== exp_line[0]) begin nfail++; $display("FAIL busy_start write: index %0d required 40, slot %0d", obs_idx[w0], first_diff(obs_line[w0], exp_line[0])); end
    end
    nvec++; if (int'(bram_index) != 41 || done_cnt - d0 != 1) begin nfail++; $display("FAIL busy_start end: index %0d dones %0d required 41 1", bram_index, done_cnt - d0); end
  endtask

  task automatic test_random;
    int lc, idx, kind, n, tl;
    for (int it = 0; it < 6; it++) begin
      lc   = $urandom_range(1, 3);
      idx  = $urandom_range(0, (1 << AW) - 1);
      kind = $urandom_range(0, 2);
      n    = lc * NW;
      tl   = (kind == 0) ? n - 1 : (kind == 1) ? $urandom_range(0, n - 2) : -1;
      test_framing(idx, lc, n, tl, 2, "random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal(0, "nominal");
    test_framing(0, 1, 10, 9, 0, "early_tlast");
    test_framing(7, 1, NW, -1, 0, "missing_tlast");
    test_nominal(1, "bubbles");
    test_reset_mid_line();
    test_line_count_zero();
    test_framing(511, 2, 2*NW, 2*NW - 1, 0, "wrap");
    test_start_during_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
